instruction_fetch: RTL and testbench
====================================

# instruction_fetch

Fetch stage directly upstream of the instruction decoder. Holds the program counter, issues one instruction-memory read at a time, and presents the fetched word and its PC to decode through an IF/ID register (`instruction`, `PCo`). It honours a stall from the hazard logic through a one-entry skid buffer. It also honours a branch redirect from execute, which squashes in-flight and buffered instructions.

## Interface
- `bus`, 32: PC / address width.
- `RESET_PC`, 0: PC value loaded on reset.
- `PC_STEP`, 4: sequential PC increment (byte addressing).

Ports:
- `clk`  in  1  sole clock; all state on rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  decode cannot accept; IF/ID must hold.
- `branch_taken`  in  1  single-cycle redirect pulse from execute.
- `branch_target`  in  bus  new PC when `branch_taken`=1.
- `imem_req`  out  1  read request, valid for one cycle.
- `imem_addr`  out  bus  read address; equals PC register when `imem_req`=1.
- `imem_valid`  in  1  read data valid, ≥1 cycle after request.
- `imem_data`  in  32  instruction word returned with `imem_valid`.
- `instruction`  out  32  IF/ID instruction to decoder.
- `PCo`  out  bus  PC of `instruction`.
- `if_valid`  out  1  IF/ID contents are a real instruction (0 = bubble).

## Operation
Registers:
- `pc_q`: PC register.
- IF/ID: `instruction`, `PCo`, `if_valid`.
- Skid buffer: `skid_instr`, `skid_pc`, `skid_valid`.
- `state`: FSM state.

FSM states:
- **REQ**: `imem_req` = ~`branch_taken`; `imem_addr` = `pc_q`.
  - If a request is issued: capture `req_pc` ← `pc_q`, advance `pc_q` ← `pc_q` + `PC_STEP`, go to WAIT.
  - If `branch_taken`: no request, `pc_q` ← `branch_target`, stay in REQ.
- **WAIT**: await `imem_valid`.
  - `branch_taken` without `imem_valid`: go to DRAIN.
  - `branch_taken` with `imem_valid`: discard data, go to REQ.
  - `imem_valid` and ~`stall`: load IF/ID with {`imem_data`, `req_pc`, 1}, go to REQ.
  - `imem_valid` and `stall`: load skid with {`imem_data`, `req_pc`}, `skid_valid` ← 1, go to HOLD.
- **HOLD**: no request.
  - On ~`stall`: IF/ID ← skid, `skid_valid` ← 0, go to REQ.
- **DRAIN**: no request. Discard the next `imem_valid`, then go to REQ.

IF/ID update rules:
- When ~`stall` and nothing is loaded that cycle: `if_valid` ← 0 (bubble). `instruction`/`PCo` keep their old values.
- When `stall`: IF/ID unchanged.

Redirect rules:
- `branch_taken` has priority over `stall` and over every response.
- It sets `pc_q` ← `branch_target`, `if_valid` ← 0, `skid_valid` ← 0.
- From HOLD it goes to REQ.

Other rules:
- `imem_valid` in REQ or HOLD is ignored (spurious).
- Only one request is ever outstanding.
- PC arithmetic is modulo 2^bus; wrap from max to 0 is legal and silent.

## Timing
Reset values (async, on `rst_n`=0):
- `pc_q` = `RESET_PC`, `state` = REQ.
- `if_valid` = 0, `instruction` = 0, `PCo` = 0.
- `skid_valid` = 0, `imem_req` = 0 while in reset.

Latency and throughput:
- First `imem_req` is in the first cycle after `rst_n` rises.
- With 1-cycle memory, `if_valid` rises 2 cycles after the request.
- Steady-state throughput is one instruction per 2 cycles.
- `imem_req` and `imem_addr` are combinational from `state`, `pc_q` and `branch_taken`. All other outputs are registered.
- Redirect costs every instruction fetched after the branch. First request to `branch_target` is in the cycle after `branch_taken`, or the cycle after the discarded response when in DRAIN.

Reset mid-operation: any outstanding response after reset release arrives in REQ state and is ignored.

## Structure
- Shared package `processor_pkg` holds `fetch_state_t` (REQ, WAIT, HOLD, DRAIN) and the `RESET_PC` / `PC_STEP` defaults used across the pipeline.
- One natural sub-module: `fetch_skid_buffer`, the one-entry buffer with load, drain and flush controls.

## Test plan
- Reset release, 1-cycle memory, no stall:
  - `imem_addr` = 0, 4, 8 on alternate cycles.
  - `PCo`/`instruction` follow with `if_valid`=1 every other cycle.
- Stall held 3 cycles while the response for PC 8 arrives:
  - Data goes to skid, state is HOLD, no new request.
  - On release, `PCo`=8 appears, then a request to 12.
- `branch_taken`, `branch_target`=0x100 in WAIT, response delayed 2 cycles:
  - Response discarded, `if_valid`=0.
  - Next `imem_addr`=0x100.
- `branch_taken` in the same cycle as `imem_valid`: data dropped, request to target the next cycle.
- `branch_taken` during HOLD with `stall`=1: skid flushed, `if_valid`=0, request to target the next cycle.
- `rst_n` pulsed low while in WAIT:
  - Outputs cleared immediately.
  - Late `imem_valid` ignored; fetch restarts at `RESET_PC`.

Source files
------------

// File: rtl/processor_pkg.sv
// Shared pipeline definitions: fetch FSM encoding and PC defaults used by
// every stage that needs to know where execution starts and how it advances.
package processor_pkg;

  typedef enum logic [1:0] {
    REQ   = 2'd0,
    WAIT  = 2'd1,
    HOLD  = 2'd2,
    DRAIN = 2'd3
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] PC_STEP_DEFAULT  = 32'd4;

endpackage

// File: rtl/instruction_fetch_if.sv
// Instruction-memory read port: single request, one response per request.
interface instruction_fetch_if #(
  parameter int bus = 32
);
  logic           imem_req;
  logic [bus-1:0] imem_addr;
  logic           imem_valid;
  logic [31:0]    imem_data;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_valid,
    input  imem_data
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_valid,
    output imem_data
  );
endinterface

// File: rtl/fetch_skid_buffer.sv
// One-entry holding slot for a fetched word that arrived while decode stalled.
module fetch_skid_buffer #(
  parameter int bus = 32
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           load,
  input  logic           drain,
  input  logic           flush,
  input  logic [31:0]    load_instr,
  input  logic [bus-1:0] load_pc,
  output logic [31:0]    skid_instr,
  output logic [bus-1:0] skid_pc,
  output logic           skid_valid
);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      skid_valid <= 1'b0;
    end else if (flush) begin
      skid_valid <= 1'b0;
    end else if (load) begin
      skid_valid <= 1'b1;
    end else if (drain) begin
      skid_valid <= 1'b0;
    end
  end

  // Payload carries no reset: it is only observed while skid_valid is set.
  always_ff @(posedge clk) begin
    if (load) begin
      skid_instr <= load_instr;
      skid_pc    <= load_pc;
    end
  end

endmodule

// File: rtl/instruction_fetch.sv
// Fetch stage: PC register, single-outstanding imem read, IF/ID register,
// stall absorption via a one-entry skid buffer, and branch redirect squash.
module instruction_fetch
  import processor_pkg::*;
#(
  parameter int             bus      = 32,
  parameter logic [bus-1:0] RESET_PC = RESET_PC_DEFAULT[bus-1:0],
  parameter logic [bus-1:0] PC_STEP  = PC_STEP_DEFAULT[bus-1:0]
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  stall,
  input  logic                  branch_taken,
  input  logic [bus-1:0]        branch_target,
  instruction_fetch_if.master   imem,
  output logic [31:0]           instruction,
  output logic [bus-1:0]        PCo,
  output logic                  if_valid
);

  fetch_state_t   state;
  logic [bus-1:0] pc_q;
  logic [bus-1:0] req_pc;
  logic           req_fire;
  logic           skid_load;
  logic           skid_drain;
  logic [31:0]    skid_instr;
  logic [bus-1:0] skid_pc;
  logic           skid_valid;

  function automatic logic [bus-1:0] pc_advance(input logic [bus-1:0] pc);
    return pc + PC_STEP;
  endfunction

  // Request is gated by rst_n so nothing is issued while reset is held.
  assign req_fire       = rst_n && (state == REQ) && !branch_taken;
  assign imem.imem_req  = req_fire;
  assign imem.imem_addr = pc_q;

  assign skid_load  = (state == WAIT) && imem.imem_valid && stall && !branch_taken;
  assign skid_drain = (state == HOLD) && skid_valid && !stall && !branch_taken;

  fetch_skid_buffer #(.bus(bus)) u_skid (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (skid_load),
    .drain      (skid_drain),
    .flush      (branch_taken),
    .load_instr (imem.imem_data),
    .load_pc    (req_pc),
    .skid_instr (skid_instr),
    .skid_pc    (skid_pc),
    .skid_valid (skid_valid)
  );

  always_ff @(posedge clk) begin
    if (req_fire) begin
      req_pc <= pc_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= REQ;
      pc_q        <= RESET_PC;
      if_valid    <= 1'b0;
      instruction <= '0;
      PCo         <= '0;
    end else begin
      // Redirect wins over stall; otherwise an unloaded, unstalled IF/ID bubbles.
      if (branch_taken) begin
        pc_q     <= branch_target;
        if_valid <= 1'b0;
      end else if (!stall) begin
        if_valid <= 1'b0;
      end

      case (state)
        REQ: begin
          if (!branch_taken) begin
            pc_q  <= pc_advance(pc_q);
            state <= WAIT;
          end
        end
        WAIT: begin
          if (branch_taken) begin
            state <= imem.imem_valid ? REQ : DRAIN;
          end else if (imem.imem_valid) begin
            if (!stall) begin
              instruction <= imem.imem_data;
              PCo         <= req_pc;
              if_valid    <= 1'b1;
              state       <= REQ;
            end else begin
              state <= HOLD;
            end
          end
        end
        HOLD: begin
          if (branch_taken) begin
            state <= REQ;
          end else if (skid_drain) begin
            instruction <= skid_instr;
            PCo         <= skid_pc;
            if_valid    <= 1'b1;
            state       <= REQ;
          end
        end
        DRAIN: begin
          // The squashed response is still in flight; swallow it before refetching.
          if (imem.imem_valid) begin
            state <= REQ;
          end
        end
        default: state <= REQ;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed vector table, reset-in-WAIT sequence,
// then randomized traffic against a transaction-level reference model.
module tb_instruction_fetch;
  import processor_pkg::*;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        stall = 1'b0;
  logic        branch_taken = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] instruction;
  logic [31:0] PCo;
  logic        if_valid;

  instruction_fetch_if #(.bus(32)) imem_bus ();

  instruction_fetch #(.bus(32), .RESET_PC(32'h0), .PC_STEP(32'd4)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_target (branch_target),
    .imem          (imem_bus),
    .instruction   (instruction),
    .PCo           (PCo),
    .if_valid      (if_valid)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic        s;
    logic        b;
    logic [31:0] t;
    logic        m;
    logic [31:0] d;
    logic        exp_req;
    logic [31:0] exp_addr;
    logic        exp_ifv;
    logic [31:0] exp_pco;
  } vec_t;

  vec_t vecs[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic vec_t mk(input logic s, input logic b, input logic [31:0] t,
                              input logic m, input logic [31:0] ma,
                              input logic r, input logic [31:0] ra,
                              input logic iv, input logic [31:0] pc);
    vec_t v;
    v.s = s; v.b = b; v.t = t; v.m = m;
    v.d = m ? mem_word(ma) : 32'h0;
    v.exp_req = r; v.exp_addr = ra; v.exp_ifv = iv; v.exp_pco = pc;
    return v;
  endfunction

  task automatic drive(input logic s, input logic b, input logic [31:0] t,
                       input logic m, input logic [31:0] d);
    stall = s;
    branch_taken = b;
    branch_target = t;
    imem_bus.imem_valid = m;
    imem_bus.imem_data = d;
  endtask

  // Reference model state (transaction level: outstanding read, held word, IF/ID)
  logic [31:0] m_pc;
  logic        m_busy, m_squash;
  logic [31:0] m_out_pc;
  logic        m_skid_v;
  logic [31:0] m_skid_i, m_skid_pc;
  logic        m_ifv;
  logic [31:0] m_instr, m_pco;

  initial begin
    imem_bus.imem_valid = 1'b0;
    imem_bus.imem_data  = 32'h0;

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    check("rst_if_valid", {31'b0, if_valid}, 32'h0);
    check("rst_pco", PCo, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    rst_n = 1'b1;

    //            s  b  t         m  ma             r  ra        iv pc
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h0,        0, 32'h0,   1, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h4,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h4,        0, 32'h0,   1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        1, 32'h8,   1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,   1, 32'h8,        0, 32'h0,   1, 32'h4));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 32'h4));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   1, 32'h8));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'hC,   0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h100, 0, 32'h0,        0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'hC,        0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h100, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h100,      0, 32'h0,   1, 32'h100));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h104, 0, 32'h0));
    vecs.push_back(mk(0, 1, 32'h200, 1, 32'h104,      0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   0, 32'h0,        1, 32'h200, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h200,      0, 32'h0,   1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        1, 32'h204, 1, 32'h200));
    vecs.push_back(mk(1, 0, 32'h0,   1, 32'h204,      0, 32'h0,   1, 32'h200));
    vecs.push_back(mk(1, 1, 32'h300, 0, 32'h0,        0, 32'h0,   0, 32'h0));
    vecs.push_back(mk(1, 0, 32'h0,   0, 32'h0,        1, 32'h300, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h300,      0, 32'h0,   1, 32'h300));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'hDEAD0000, 1, 32'h304, 0, 32'h0));
    vecs.push_back(mk(0, 0, 32'h0,   1, 32'h304,      0, 32'h0,   1, 32'h304));

    // rst_n rose at posedge+1; each vector covers one full cycle from here
    foreach (vecs[i]) begin
      drive(vecs[i].s, vecs[i].b, vecs[i].t, vecs[i].m, vecs[i].d);
      #3;
      check($sformatf("vec%0d_req", i), {31'b0, imem_bus.imem_req}, {31'b0, vecs[i].exp_req});
      if (vecs[i].exp_req)
        check($sformatf("vec%0d_addr", i), imem_bus.imem_addr, vecs[i].exp_addr);
      @(posedge clk);
      #1;
      check($sformatf("vec%0d_ifv", i), {31'b0, if_valid}, {31'b0, vecs[i].exp_ifv});
      if (vecs[i].exp_ifv) begin
        check($sformatf("vec%0d_pco", i), PCo, vecs[i].exp_pco);
        check($sformatf("vec%0d_instr", i), instruction, mem_word(vecs[i].exp_pco));
      end
    end

    // Reset pulsed while a read to 0x308 is outstanding
    drive(0, 0, 32'h0, 0, 32'h0);
    #3;
    check("mid_req", {31'b0, imem_bus.imem_req}, 32'h1);
    check("mid_addr", imem_bus.imem_addr, 32'h308);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_ifv", {31'b0, if_valid}, 32'h0);
    check("mid_rst_pco", PCo, 32'h0);
    check("mid_rst_instr", instruction, 32'h0);
    check("mid_rst_req", {31'b0, imem_bus.imem_req}, 32'h0);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    drive(0, 0, 32'h0, 1, mem_word(32'h308));
    #3;
    check("late_req", {31'b0, imem_bus.imem_req}, 32'h1);
    check("late_addr", imem_bus.imem_addr, 32'h0);
    @(posedge clk);
    #1;
    check("late_ifv", {31'b0, if_valid}, 32'h0);
    drive(0, 0, 32'h0, 1, mem_word(32'h0));
    #3;
    check("restart_req", {31'b0, imem_bus.imem_req}, 32'h0);
    @(posedge clk);
    #1;
    check("restart_ifv", {31'b0, if_valid}, 32'h1);
    check("restart_pco", PCo, 32'h0);
    check("restart_instr", instruction, mem_word(32'h0));

    // Randomized run against the reference model
    drive(0, 0, 32'h0, 0, 32'h0);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    m_pc = 32'h0; m_busy = 1'b0; m_squash = 1'b0; m_out_pc = 32'h0;
    m_skid_v = 1'b0; m_skid_i = 32'h0; m_skid_pc = 32'h0;
    m_ifv = 1'b0; m_instr = 32'h0; m_pco = 32'h0;
    begin
      int          mem_cnt;
      logic [31:0] mem_addr;
      logic        prev_b;
      mem_cnt = 0;
      mem_addr = 32'h0;
      prev_b = 1'b0;
      for (int n = 0; n < 600; n++) begin
        logic        s, b, v, exp_req, resp;
        logic [31:0] t, d;
        s = ($urandom % 10) < 3;
        b = !prev_b && (($urandom % 12) == 0);
        t = (($urandom % 4) == 0) ? 32'hFFFF_FFF8 : (32'($urandom_range(0, 4095)) << 2);
        d = $urandom;
        if (mem_cnt == 1) begin
          v = 1'b1;
          d = mem_word(mem_addr);
          mem_cnt = 0;
        end else if (mem_cnt > 1) begin
          v = 1'b0;
          mem_cnt--;
        end else begin
          v = (($urandom % 20) == 0);
        end
        prev_b = b;
        drive(s, b, t, v, d);
        #3;
        exp_req = !m_busy && !m_skid_v && !b;
        check("rnd_req", {31'b0, imem_bus.imem_req}, {31'b0, exp_req});
        if (exp_req) check("rnd_addr", imem_bus.imem_addr, m_pc);
        if (imem_bus.imem_req) begin
          mem_cnt = $urandom_range(1, 3);
          mem_addr = imem_bus.imem_addr;
        end

        resp = v && m_busy;
        if (!s) m_ifv = 1'b0;
        if (b) begin
          m_pc = t;
          m_ifv = 1'b0;
          m_skid_v = 1'b0;
          if (resp) m_busy = 1'b0;
          else if (m_busy) m_squash = 1'b1;
        end else if (exp_req) begin
          m_busy = 1'b1;
          m_squash = 1'b0;
          m_out_pc = m_pc;
          m_pc = m_pc + 32'd4;
        end else if (resp) begin
          m_busy = 1'b0;
          if (!m_squash) begin
            if (!s) begin
              m_ifv = 1'b1; m_instr = d; m_pco = m_out_pc;
            end else begin
              m_skid_v = 1'b1; m_skid_i = d; m_skid_pc = m_out_pc;
            end
          end
        end else if (m_skid_v && !s) begin
          m_skid_v = 1'b0;
          m_ifv = 1'b1; m_instr = m_skid_i; m_pco = m_skid_pc;
        end

        @(posedge clk);
        #1;
        check("rnd_ifv", {31'b0, if_valid}, {31'b0, m_ifv});
        check("rnd_pco", PCo, m_pco);
        check("rnd_instr", instruction, m_instr);
      end
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
